// File: rtl/mips_ctrl_pkg.sv
// ============================================================================
// Module      : mips_ctrl_pkg
// Description : Shared control constants for the multicycle MIPS controller:
//               main FSM state encoding, opcode values and ALU-decoder codes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_ctrl_pkg;

  // Main FSM state encoding (also exported on the debug state port)
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_BNEEX   = 4'd12
  } state_t;

  // Opcode field values (instr[31:26])
  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_J     = 6'b000010;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_BNE   = 6'b000101;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;

  // aluop codes understood by the ALU decoder
  localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
  localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
  localparam logic [1:0] c_ALUOP_FUNCT = 2'b10;

  // alusrcb mux selects
  localparam logic [1:0] c_SRCB_REG  = 2'b00;
  localparam logic [1:0] c_SRCB_FOUR = 2'b01;
  localparam logic [1:0] c_SRCB_IMM  = 2'b10;
  localparam logic [1:0] c_SRCB_BOFS = 2'b11;

  // pcsrc mux selects
  localparam logic [1:0] c_PCSRC_ALU    = 2'b00;
  localparam logic [1:0] c_PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] c_PCSRC_JUMP   = 2'b10;

endpackage

`default_nettype wire

// File: rtl/main_fsm.sv
// ============================================================================
// Module      : main_fsm
// Description : Moore main controller for the 32-bit multicycle MIPS
//               datapath. The state register is the only flop; next-state
//               and datapath controls are decoded combinationally from it.
//               Optional feature macro: MAIN_FSM_BNE_EN (adds bne / BNEEX).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module main_fsm
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  output logic       pcen,
  output logic       irwrite,
  output logic       memwrite,
  output logic       iord,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic       branch,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic [3:0] state
);

  state_t r_state;
  state_t w_next_state;
  logic   w_pcwrite;
`ifdef MAIN_FSM_BNE_EN
  logic   w_bne;
`endif

  // State register: asynchronous active-low reset forces FETCH at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; op is only consulted in DECODE and MEMADR
  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH:   w_next_state = S_DECODE;
      S_DECODE: begin
        case (op)
          c_OP_LW,
          c_OP_SW:    w_next_state = S_MEMADR;
          c_OP_RTYPE: w_next_state = S_EXECUTE;
          c_OP_BEQ:   w_next_state = S_BEQEX;
          c_OP_ADDI:  w_next_state = S_ADDIEX;
          c_OP_J:     w_next_state = S_JEX;
`ifdef MAIN_FSM_BNE_EN
          c_OP_BNE:   w_next_state = S_BNEEX;
`endif
          // Unknown opcodes restart fetch without touching regs or memory
          default:    w_next_state = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        // Anything other than lw/sw here can only be a corrupted IR; drop it
        if (op == c_OP_LW) begin
          w_next_state = S_MEMRD;
        end else if (op == c_OP_SW) begin
          w_next_state = S_MEMWR;
        end else begin
          w_next_state = S_FETCH;
        end
      end
      S_MEMRD:   w_next_state = S_MEMWB;
      S_EXECUTE: w_next_state = S_ALUWB;
      S_ADDIEX:  w_next_state = S_ADDIWB;
      default:   w_next_state = S_FETCH;
    endcase
  end

  // Moore output decode: every control is a pure function of the state
  always_comb begin
    w_pcwrite = 1'b0;
    irwrite   = 1'b0;
    memwrite  = 1'b0;
    iord      = 1'b0;
    regwrite  = 1'b0;
    regdst    = 1'b0;
    memtoreg  = 1'b0;
    alusrca   = 1'b0;
    branch    = 1'b0;
    alusrcb   = c_SRCB_REG;
    pcsrc     = c_PCSRC_ALU;
    aluop     = c_ALUOP_ADD;
`ifdef MAIN_FSM_BNE_EN
    w_bne     = 1'b0;
`endif
    case (r_state)
      S_FETCH: begin
        alusrcb   = c_SRCB_FOUR;
        irwrite   = 1'b1;
        w_pcwrite = 1'b1;
      end
      S_DECODE: alusrcb = c_SRCB_BOFS;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = c_SRCB_IMM;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = c_ALUOP_FUNCT;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        aluop   = c_ALUOP_SUB;
        pcsrc   = c_PCSRC_ALUOUT;
        branch  = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = c_SRCB_IMM;
      end
      S_ADDIWB: regwrite = 1'b1;
      S_JEX: begin
        pcsrc     = c_PCSRC_JUMP;
        w_pcwrite = 1'b1;
      end
`ifdef MAIN_FSM_BNE_EN
      S_BNEEX: begin
        alusrca = 1'b1;
        aluop   = c_ALUOP_SUB;
        pcsrc   = c_PCSRC_ALUOUT;
        w_bne   = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // PC enable is the only output that also looks at the ALU zero flag
`ifdef MAIN_FSM_BNE_EN
  assign pcen = w_pcwrite | (branch & zero) | (w_bne & ~zero);
`else
  assign pcen = w_pcwrite | (branch & zero);
`endif

  assign state = r_state;

endmodule

`default_nettype wire

// File: doc/main_fsm.md
MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 The module SHALL have no parameters; widths are fixed by the 32-bit multicycle MIPS datapath.
REQ-002 clk  input  1  rising-edge clock, shared with the datapath flopenr registers.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 asserts.
REQ-004 op  input  6  opcode field (instr[31:26]) from the instruction register.
REQ-005 zero  input  1  ALU zero flag.
REQ-006 pcen  output  1  enable for the PC flopenr.
REQ-007 irwrite  output  1  enable for the IR flopenr.
REQ-008 memwrite, iord, regwrite, regdst, memtoreg, alusrca, branch  output  1 each  datapath controls.
REQ-009 alusrcb, pcsrc, aluop  output  2 each  datapath mux and ALU-decoder selects.
REQ-010 state  output  4  current state encoding, for debug.

Function
REQ-011 The FSM SHALL be Moore: all outputs except pcen SHALL be decoded from state only.
REQ-012 The encoding SHALL be FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11, BNEEX=12.
REQ-013 Transitions SHALL be FETCH->DECODE.
REQ-014 From DECODE, by op: lw 100011 and sw 101011 ->MEMADR; R-type 000000 ->EXECUTE; beq 000100 ->BEQEX; addi 001000 ->ADDIEX; j 000010 ->JEX.
REQ-015 Further transitions: MEMADR: lw->MEMRD, sw->MEMWR; MEMRD->MEMWB; EXECUTE->ALUWB; ADDIEX->ADDIWB.
REQ-016 MEMWB, MEMWR, ALUWB, BEQEX, ADDIWB, JEX and BNEEX SHALL all go ->FETCH.
REQ-017 An unrecognised op in DECODE SHALL go ->FETCH with no register or memory write.
REQ-018 Every output not listed for a state SHALL be 0.
REQ-019 FETCH: alusrcb=01, irwrite=1, pcwrite=1.
REQ-020 DECODE: alusrcb=11. MEMADR: alusrca=1, alusrcb=10.
REQ-021 MEMRD: iord=1. MEMWB: memtoreg=1, regwrite=1. MEMWR: iord=1, memwrite=1.
REQ-022 EXECUTE: alusrca=1, aluop=10. ALUWB: regdst=1, regwrite=1.
REQ-023 BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1.
REQ-024 ADDIEX: alusrca=1, alusrcb=10. ADDIWB: regwrite=1. JEX: pcsrc=10, pcwrite=1.
REQ-025 pcen SHALL be the combinational function pcwrite | (branch & zero), where pcwrite is an internal state decode; it is the only input-dependent output.
REQ-026 Instruction latency SHALL be: lw 5 cycles, sw/R/addi 4 cycles, beq/j 3 cycles.
REQ-027 op SHALL be sampled only in DECODE and MEMADR; op changes in any other state SHALL have no effect.

Reset
REQ-028 reset=0 SHALL force state to FETCH immediately, independent of clk.
REQ-029 While reset=0, outputs SHALL show FETCH decode: irwrite=1, pcen=1, alusrcb=01, all else 0.
REQ-030 Deassertion SHALL take effect at the next rising clk edge; the first edge after deassertion moves to DECODE.
REQ-031 Reset asserted mid-instruction SHALL abort the instruction with no further write strobes.

Configuration
REQ-032 With MAIN_FSM_BNE_EN defined: DECODE with op 000101 SHALL go ->BNEEX.
REQ-033 BNEEX SHALL drive alusrca=1, aluop=01, pcsrc=01, and an internal bne=1.
REQ-034 With MAIN_FSM_BNE_EN defined, pcen SHALL be pcwrite | (branch & zero) | (bne & ~zero).
REQ-035 Without MAIN_FSM_BNE_EN, op 000101 SHALL be unrecognised (REQ-017) and encoding 12 SHALL be unreachable.

Structure
REQ-036 State encodings, opcode constants and aluop codes SHALL live in a shared package mips_ctrl_pkg, shared with the ALU decoder.
REQ-037 The state register SHALL be the only sequential element; next-state and output decode SHALL be combinational.
REQ-038 No sub-module is required.

Verification
REQ-039 Reset pulse low for 3 cycles -> state=0, irwrite=1, pcen=1 during reset; state=1 one edge after release.
REQ-040 op=100011 (lw) -> state sequence 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4.
REQ-041 op=000100, zero=1 -> pcen=1 in state 8; repeat with zero=0 -> pcen=0 in state 8.
REQ-042 op=111111 -> 0,1,0, with memwrite=regwrite=0 throughout.
REQ-043 sw sequence with reset dropped in state 2 -> state=0 at once; memwrite is never 1.
REQ-044 MAIN_FSM_BNE_EN build, op=000101: zero=0 -> state 12, pcen=1; zero=1 -> pcen=0. Non-BNE build, same op -> 0,1,0.
